jtl_delay_checker: RTL and testbench

//  Receive-side checker for a JTL pulse link under simulation.

---
 rtl/jtl_delay_checker.sv | 184 ++++++++++++++++++
 tb/tb_jtl_delay_checker.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtl_delay_checker.sv
// jtl_delay_checker: receive-side checker for a toggle-encoded JTL pulse link.
// Every level change on in_sig launches a pulse and is timestamped into a small
// FIFO. Every level change on out_sig is an arrival that is matched in FIFO order.
// The launch-to-arrival delay is checked against [MIN_DLY, MAX_DLY]. The checker
// reports early, late, missing, spurious and overflow events, and it keeps
// saturating pass and fail counts.
module jtl_delay_checker #(
    parameter int TS_W        = 16,
    parameter int DEPTH       = 4,
    parameter int MIN_DLY     = 2,
    parameter int MAX_DLY     = 10,
    parameter int CNT_W       = 16,
    parameter int STOP_ON_ERR = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   in_sig,
    input  logic                   out_sig,
    output logic [TS_W-1:0]        dly,
    output logic                   dly_valid,
    output logic                   err_early,
    output logic                   err_late,
    output logic                   err_missing,
    output logic                   err_spurious,
    output logic                   err_overflow,
    output logic [$clog2(DEPTH):0] pending,
    output logic [CNT_W-1:0]       pass_cnt,
    output logic [CNT_W-1:0]       fail_cnt,
    output logic                   fault
);

    localparam int               AW      = $clog2(DEPTH);
    localparam logic [TS_W-1:0]  MIN_T   = TS_W'(MIN_DLY);
    localparam logic [TS_W-1:0]  MAX_T   = TS_W'(MAX_DLY);
    localparam logic [AW:0]      FULL    = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

    state_t state_q, state_d;

    logic              in_q, out_q;
    logic [TS_W-1:0]   now;
    logic [TS_W-1:0]   mem [DEPTH];
    logic [AW-1:0]     rd_ptr, wr_ptr;

    logic              run, flush;
    logic              ev_in, ev_out, empty;
    logic [TS_W-1:0]   age;
    logic              pop_match, spurious, missing, pop, push, overflow;
    logic              early, late, in_range, err_any;
    logic [AW:0]       occ_after_pop;
    logic [2:0]        n_err;
    logic [CNT_W:0]    fail_sum;

    // Event detection and the per-cycle decisions. Timestamps are compared
    // modulo 2**TS_W, so a wrap of now between launch and arrival is harmless.
    assign ev_in     = in_sig ^ in_q;
    assign ev_out    = out_sig ^ out_q;
    assign empty     = (pending == '0);
    assign age       = now - mem[rd_ptr];

    assign pop_match = ev_out && !empty;
    assign spurious  = ev_out && empty;
    // A real arrival wins over ageing out, so the same pulse is reported late, not missing.
    assign missing   = !ev_out && !empty && (age > MAX_T);
    assign pop       = pop_match || missing;

    // Space freed by this cycle's pop is available to this cycle's launch.
    assign occ_after_pop = pending - (AW+1)'(pop);
    assign push          = ev_in && (occ_after_pop != FULL);
    assign overflow      = ev_in && !push;

    assign early    = pop_match && (age < MIN_T);
    assign late     = pop_match && (age > MAX_T);
    assign in_range = pop_match && !early && !late;
    assign err_any  = early || late || missing || spurious || overflow;

    assign n_err    = 3'(early) + 3'(late) + 3'(missing) + 3'(spurious) + 3'(overflow);
    assign fail_sum = {1'b0, fail_cnt} + (CNT_W+1)'(n_err);

    assign fault    = (state_q == FAULT);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so that every
        // flop samples values from before the edge, independent of block order.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic and the run/flush qualifiers for the datapath.
    always_comb begin
        // NOTE: every output of this block gets a default first; an output left
        // unassigned on some path would infer a latch.
        state_d = state_q;
        run     = 1'b0;
        flush   = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) state_d = RUN;
            end
            RUN: begin
                if (!en) begin
                    state_d = IDLE;
                    flush   = 1'b1;
                end else begin
                    run = 1'b1;
                    if ((STOP_ON_ERR != 0) && err_any) state_d = FAULT;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Timestamp storage; a slot is written only on an accepted launch.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset. Occupancy is tracked by pending
        // and the pointers, so stale slot contents are never observed.
        if (run && push) mem[wr_ptr] <= now;
    end

    // Edge history, time base, FIFO pointers, result strobes and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            // Loading the live levels means a static line never looks like a toggle.
            in_q         <= in_sig;
            out_q        <= out_sig;
            now          <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            pending      <= '0;
            dly          <= '0;
            dly_valid    <= 1'b0;
            err_early    <= 1'b0;
            err_late     <= 1'b0;
            err_missing  <= 1'b0;
            err_spurious <= 1'b0;
            err_overflow <= 1'b0;
            pass_cnt     <= '0;
            fail_cnt     <= '0;
        end else begin
            in_q         <= in_sig;
            out_q        <= out_sig;
            now          <= now + 1'b1;
            dly_valid    <= 1'b0;
            err_early    <= 1'b0;
            err_late     <= 1'b0;
            err_missing  <= 1'b0;
            err_spurious <= 1'b0;
            err_overflow <= 1'b0;

            if (flush) begin
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                pending <= '0;
            end

            if (run) begin
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                if (push) wr_ptr <= wr_ptr + 1'b1;
                pending <= occ_after_pop + (AW+1)'(push);

                dly_valid    <= pop_match;
                if (pop_match) dly <= age;
                err_early    <= early;
                err_late     <= late;
                err_missing  <= missing;
                err_spurious <= spurious;
                err_overflow <= overflow;

                if (in_range && (pass_cnt != CNT_MAX)) pass_cnt <= pass_cnt + 1'b1;
                fail_cnt <= fail_sum[CNT_W] ? CNT_MAX : fail_sum[CNT_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_jtl_delay_checker.sv
// Self-checking bench for jtl_delay_checker.
// Instance a keeps checking after errors and uses the default 16-bit time base.
// Instance b latches FAULT on the first error. It uses a 5-bit time base, so the
// launch/arrival chain crosses several counter wraps.
// Expected strobes are queued when stimulus is driven. The monitors pop and
// compare them, including the clock edge at which each one must appear.
module tb_jtl_delay_checker;

    localparam logic [5:0] V     = 6'b100000;
    localparam logic [5:0] EARLY = 6'b010000;
    localparam logic [5:0] LATE  = 6'b001000;
    localparam logic [5:0] MISS  = 6'b000100;
    localparam logic [5:0] SPUR  = 6'b000010;
    localparam logic [5:0] OVF   = 6'b000001;

    typedef struct {
        int         at_edge;
        logic [5:0] ev;
        int         dly;
    } exp_t;

    logic clk;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t qa[$];
    exp_t qb[$];

    logic        a_rst, a_en, a_in, a_out;
    logic [15:0] a_dly;
    logic        a_dly_valid, a_early, a_late, a_missing, a_spurious, a_overflow, a_fault;
    logic [2:0]  a_pending;
    logic [15:0] a_pass_cnt, a_fail_cnt;

    logic        b_rst, b_en, b_in, b_out;
    logic [4:0]  b_dly;
    logic        b_dly_valid, b_early, b_late, b_missing, b_spurious, b_overflow, b_fault;
    logic [2:0]  b_pending;
    logic [15:0] b_pass_cnt, b_fail_cnt;

    jtl_delay_checker #(.STOP_ON_ERR(0)) u_a (
        .clk(clk), .rst(a_rst), .en(a_en), .in_sig(a_in), .out_sig(a_out),
        .dly(a_dly), .dly_valid(a_dly_valid), .err_early(a_early), .err_late(a_late),
        .err_missing(a_missing), .err_spurious(a_spurious), .err_overflow(a_overflow),
        .pending(a_pending), .pass_cnt(a_pass_cnt), .fail_cnt(a_fail_cnt), .fault(a_fault)
    );

    jtl_delay_checker #(.TS_W(5), .STOP_ON_ERR(1)) u_b (
        .clk(clk), .rst(b_rst), .en(b_en), .in_sig(b_in), .out_sig(b_out),
        .dly(b_dly), .dly_valid(b_dly_valid), .err_early(b_early), .err_late(b_late),
        .err_missing(b_missing), .err_spurious(b_spurious), .err_overflow(b_overflow),
        .pending(b_pending), .pass_cnt(b_pass_cnt), .fail_cnt(b_fail_cnt), .fault(b_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count of rising edges seen so far; read at the falling edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Launch on a, arrive d cycles later, and queue the strobe pattern expected at the arrival edge.
    task automatic a_pair(input int d, input logic [5:0] ev);
        int e0;
        a_in = ~a_in;
        e0   = cyc + 1;
        step(d);
        a_out = ~a_out;
        qa.push_back('{e0 + d, ev, d});
        step(1);
    endtask

    // Monitor for instance a.
    always @(negedge clk) begin
        logic [5:0] ev;
        exp_t       e;
        ev = {a_dly_valid, a_early, a_late, a_missing, a_spurious, a_overflow};
        if (ev != 6'b0) begin
            if (qa.size() == 0) begin
                check("a_unexpected", int'(ev), 0);
            end else begin
                e = qa.pop_front();
                check("a_edge", cyc, e.at_edge);
                check("a_ev", int'(ev), int'(e.ev));
                if (e.ev[5]) check("a_dly", int'(a_dly), e.dly);
            end
        end
    end

    // Monitor for instance b.
    always @(negedge clk) begin
        logic [5:0] ev;
        exp_t       e;
        ev = {b_dly_valid, b_early, b_late, b_missing, b_spurious, b_overflow};
        if (ev != 6'b0) begin
            if (qb.size() == 0) begin
                check("b_unexpected", int'(ev), 0);
            end else begin
                e = qb.pop_front();
                check("b_edge", cyc, e.at_edge);
                check("b_ev", int'(ev), int'(e.ev));
                if (e.ev[5]) check("b_dly", int'(b_dly), e.dly);
            end
        end
    end

    initial begin
        int e0;
        a_rst = 1'b1; a_en = 1'b0; a_in = 1'b0; a_out = 1'b0;
        b_rst = 1'b1; b_en = 1'b0; b_in = 1'b0; b_out = 1'b0;
        step(3);

        // Reset state.
        check("rst_a_pending", int'(a_pending), 0);
        check("rst_a_pass",    int'(a_pass_cnt), 0);
        check("rst_a_fail",    int'(a_fail_cnt), 0);
        check("rst_a_dly",     int'(a_dly), 0);
        check("rst_a_fault",   int'(a_fault), 0);
        check("rst_b_fault",   int'(b_fault), 0);
        check("rst_b_pending", int'(b_pending), 0);

        a_rst = 1'b0; a_en = 1'b1;
        b_rst = 1'b0; b_en = 1'b1;
        step(3);

        // In-range pair: delay 6.
        a_pair(6, V);
        step(2);
        check("t1_pass",    int'(a_pass_cnt), 1);
        check("t1_fail",    int'(a_fail_cnt), 0);
        check("t1_pending", int'(a_pending), 0);

        // Early arrival: delay 1.
        a_pair(1, V | EARLY);
        step(2);

        // Launch without arrival: the head ages out at age MAX_DLY+1.
        a_in = ~a_in;
        e0   = cyc + 1;
        qa.push_back('{e0 + 11, MISS, 0});
        step(1);
        check("t2_pending_in", int'(a_pending), 1);
        step(14);
        check("t2_fail",    int'(a_fail_cnt), 2);
        check("t2_pending", int'(a_pending), 0);

        // Range boundaries: MIN and MAX pass. An arrival at MAX+1 is late, not missing.
        a_pair(2, V);
        step(1);
        a_pair(10, V);
        step(1);
        a_pair(11, V | LATE);
        step(2);
        check("bnd_pass", int'(a_pass_cnt), 3);
        check("bnd_fail", int'(a_fail_cnt), 3);

        // Arrival with nothing pending.
        a_out = ~a_out;
        qa.push_back('{cyc + 1, SPUR, 0});
        step(2);
        check("spur_fail", int'(a_fail_cnt), 4);

        // Five launches on consecutive cycles: four are stored and the fifth overflows.
        e0 = cyc + 1;
        qa.push_back('{e0 + 4, OVF, 0});
        for (int i = 0; i < 5; i++) begin
            a_in = ~a_in;
            step(1);
        end
        check("ovf_pending", int'(a_pending), 4);
        check("ovf_fail",    int'(a_fail_cnt), 5);

        // Disabling flushes the FIFO before anything ages out, and the counts are kept.
        a_en = 1'b0;
        step(2);
        check("flush_pending", int'(a_pending), 0);
        check("flush_fail",    int'(a_fail_cnt), 5);
        check("flush_pass",    int'(a_pass_cnt), 3);
        a_in = ~a_in;
        step(2);
        a_en = 1'b1;
        step(3);
        check("idle_ignored", int'(a_pending), 0);

        // Instance b: chained pairs of delay 5. Each arrival coincides with the next
        // launch, so occupancy stays at 1. The 45-cycle chain crosses a 5-bit time-base wrap.
        b_in = ~b_in;
        step(1);
        check("chain_pend0", int'(b_pending), 1);
        step(4);
        for (int k = 0; k < 8; k++) begin
            b_in  = ~b_in;
            b_out = ~b_out;
            qb.push_back('{cyc + 1, V, 5});
            step(1);
            check("chain_pend", int'(b_pending), 1);
            step(4);
        end
        b_out = ~b_out;
        qb.push_back('{cyc + 1, V, 5});
        step(2);
        check("chain_pend_end", int'(b_pending), 0);
        check("chain_pass",     int'(b_pass_cnt), 9);
        check("chain_fail",     int'(b_fail_cnt), 0);

        // Late arrival latches FAULT. Delay 11 is the latest arrival that can still match,
        // because one cycle later the head would already have aged out.
        b_in = ~b_in;
        step(11);
        b_out = ~b_out;
        qb.push_back('{cyc + 1, V | LATE, 11});
        step(2);
        check("fault_set",  int'(b_fault), 1);
        check("fault_fail", int'(b_fail_cnt), 1);

        // In FAULT, a valid pair and a stray arrival produce no strobes and no count changes.
        b_in = ~b_in;
        step(5);
        b_out = ~b_out;
        step(3);
        b_out = ~b_out;
        step(2);
        check("frozen_pass",  int'(b_pass_cnt), 9);
        check("frozen_fail",  int'(b_fail_cnt), 1);
        check("frozen_fault", int'(b_fault), 1);
        check("frozen_dly",   int'(b_dly), 11);

        // Reset with in_sig held high clears everything and creates no launch afterwards.
        b_rst = 1'b1;
        b_in  = 1'b1;
        step(2);
        check("rst2_fault",   int'(b_fault), 0);
        check("rst2_pass",    int'(b_pass_cnt), 0);
        check("rst2_fail",    int'(b_fail_cnt), 0);
        check("rst2_pending", int'(b_pending), 0);
        check("rst2_dly",     int'(b_dly), 0);
        check("rst2_valid",   int'(b_dly_valid), 0);
        b_rst = 1'b0;
        step(6);
        check("post_rst_pending", int'(b_pending), 0);
        check("post_rst_fail",    int'(b_fail_cnt), 0);

        // Every queued strobe must have been seen.
        check("a_left", qa.size(), 0);
        check("b_left", qb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
